logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Registered, WIDTH-bit bitwise logic unit: one opcode-selected gate function
//  (AND/OR/NAND/NOR/NOT/XOR/XNOR) plus an XOR accumulator mode. Has a one-stage
//  valid/ready output register and a saturating transaction counter.
//  Sits between an operand source and a result consumer in the datapath.
// PARAMETERS
//  WIDTH  8   operand/result width in bits (>=1)
//  CNT_W  16  width of the transaction counter (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      async reset, active-high
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      unit accepts a beat this cycle
//  op         in   3      function select (see BEHAVIOUR)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  acc_clr    in   1      synchronous clear of accumulator
//  out_valid  out  1      result held in output register
//  out_ready  in   1      consumer takes result this cycle
//  y          out  WIDTH  registered result
//  txn_count  out  CNT_W  number of accepted beats, saturating
//  flag_zero  out  1      y==0 (LOGIC_FLAGS_EN only)
//  flag_par   out  1      ^y, odd parity (LOGIC_FLAGS_EN only)
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, y=0, acc=0, txn_count=0, flags=0.
//    Reset mid-transfer drops the held result; no output until a new beat.
//  - Handshake: in_ready = !out_valid | out_ready (combinational).
//    The unit accepts a beat when in_valid & in_ready.
//    Output transfer when out_valid & out_ready.
//    y is stable while out_valid & !out_ready.
//  - Latency: 1 cycle. A beat accepted at edge N gives out_valid=1 after edge N.
//    Back-to-back throughput is 1 beat/cycle while out_ready=1.
//  - Accept with output transfer in the same cycle: y is replaced and out_valid
//    stays 1. Output transfer with no accept: out_valid goes to 0 and y holds.
//  - op encoding (bitwise over WIDTH):
//    0 AND a&b
//    1 OR a|b
//    2 NAND ~(a&b)
//    3 NOR ~(a|b)
//    4 NOT ~b
//    5 XOR a^b
//    6 XNOR ~(a^b)
//    7 ACC acc^a
//  - Accumulator: register acc[WIDTH-1:0].
//    On an accepted op=7 beat: y and acc are both loaded with acc^a.
//    Other ops leave acc unchanged.
//    acc_clr=1 sets acc=0 at the next edge, independent of handshake.
//    acc_clr together with an accepted op=7 beat: y = 0^a = a and acc = a.
//    The clear applies first, then the accumulation.
//  - txn_count: increments by 1 per accepted beat and saturates at all-ones.
//    It does not wrap. It is not cleared by acc_clr.
//  - in_valid low: no state change except acc_clr and output drain.
// CONFIGURATION
//  LOGIC_FLAGS_EN defined: flag_zero and flag_par exist. They are registered
//    alongside y, computed from the value loaded into y, and reset to 0.
//  LOGIC_FLAGS_EN undefined: both flag ports and their logic are absent.
//    All other behaviour is identical.
// TESTING  (WIDTH=8, CNT_W=4)
//  1. rst=1 pulse mid-stream -> out_valid=0, y=8'h00, txn_count=0 immediately,
//     without waiting for clk.
//  2. Sweep op 0..6 with a=8'hCA, b=8'h5F, out_ready=1 -> y is
//     4A, DF, B5, 20, A0, 95, 6A, each one cycle after its accept.
//  3. op=7, a=8'h0F then 8'hF0 then 8'hFF -> y=0F, FF, 00.
//     Then acc_clr=1 with op=7, a=8'h3C -> y=3C.
//  4. out_ready=0 with result 8'h4A held -> in_ready=0, y stays 4A for 5 cycles.
//     New in_valid is not accepted. out_ready=1 with a new beat the same cycle
//     -> no bubble.
//  5. 17 accepted beats -> txn_count reaches 4'hF at beat 15 and stays 4'hF.
//  6. LOGIC_FLAGS_EN, op=0, a=8'hF0, b=8'h0F -> y=00, flag_zero=1, flag_par=0.
//     Then op=5, a=8'h01, b=8'h00 -> flag_zero=0, flag_par=1.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// Flag signals exist only when LOGIC_FLAGS_EN is defined.
interface logic_unit_pipe_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic [CNT_W-1:0] txn_count;
`ifdef LOGIC_FLAGS_EN
   logic             flag_zero;
   logic             flag_par;

   modport master (
      output in_valid, op, a, b, acc_clr, out_ready,
      input  in_ready, out_valid, y, txn_count, flag_zero, flag_par
   );
   modport slave (
      input  in_valid, op, a, b, acc_clr, out_ready,
      output in_ready, out_valid, y, txn_count, flag_zero, flag_par
   );
`else
   modport master (
      output in_valid, op, a, b, acc_clr, out_ready,
      input  in_ready, out_valid, y, txn_count
   );
   modport slave (
      input  in_valid, op, a, b, acc_clr, out_ready,
      output in_ready, out_valid, y, txn_count
   );
`endif
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with XOR accumulator, 1-deep output register and
// saturating beat counter. Define LOGIC_FLAGS_EN to add registered zero/parity flags.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   logic_unit_pipe_if.slave bus
);
   logic             accept;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] acc_base;
   logic [WIDTH-1:0] result;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.txn_count = cnt_q;

   // Clear takes effect before any accumulation in the same cycle.
   assign acc_base = bus.acc_clr ? '0 : acc_q;

   always_comb begin
      result = '0;
      case (bus.op)
         3'd0: result = bus.a & bus.b;
         3'd1: result = bus.a | bus.b;
         3'd2: result = ~(bus.a & bus.b);
         3'd3: result = ~(bus.a | bus.b);
         3'd4: result = ~bus.b;
         3'd5: result = bus.a ^ bus.b;
         3'd6: result = ~(bus.a ^ bus.b);
         3'd7: result = acc_base ^ bus.a;
         default: result = '0;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      y_d         = y_q;
      acc_d       = acc_base;
      cnt_d       = cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         y_d         = result;
         if (bus.op == 3'd7) acc_d = result;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef LOGIC_FLAGS_EN
   logic flag_zero_q, flag_par_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_zero_q <= 1'b0;
         flag_par_q  <= 1'b0;
      end else if (accept) begin
         flag_zero_q <= (result == '0);
         flag_par_q  <= ^result;
      end
   end

   assign bus.flag_zero = flag_zero_q;
   assign bus.flag_par  = flag_par_q;
`endif
endmodule
